// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DataMemory arbiter: FSM state encoding and
// requester port identifiers.
package dmem_arbiter_pkg;

    // Access sequencer states: latch a request, drive memory for one cycle,
    // then pulse the acknowledge for one cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Requester identifiers, also used as the grant / round-robin pointer value.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way request picker. With both requests present it either favours
// port 0 (fixed priority) or the port that was not served last.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    input  logic i_fixed_prio,
    output logic o_grant,
    output logic o_valid
);

    // Pick the winning port from the current requests and the last-served pointer
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        o_grant = PORT_CPU;
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            if (i_fixed_prio) begin
                o_grant = PORT_CPU;
            end else begin
                o_grant = ~i_last;
            end
        end else if (i_req1) begin
            o_grant = PORT_DBG;
        end
    end

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// Shares the single DataMemory port between the CPU load/store path (port 0)
// and the debug/DMA loader (port 1). One request is latched at a time, the
// memory signals are driven for exactly one cycle, the combinational read data
// is registered at the end of that cycle and a one-cycle ack goes back to the
// winner. Throughput is one access every three cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rstn,
    // Port 0: CPU load/store path
    input  logic              i_P0_req,
    input  logic              i_P0_we,
    input  logic              i_P0_sByte,
    input  logic [ADDR_W-1:0] i_P0_addr,
    input  logic [DATA_W-1:0] i_P0_wData,
    output logic              o_P0_ack,
    output logic [DATA_W-1:0] o_P0_rData,
    // Port 1: debug/DMA loader
    input  logic              i_P1_req,
    input  logic              i_P1_we,
    input  logic              i_P1_sByte,
    input  logic [ADDR_W-1:0] i_P1_addr,
    input  logic [DATA_W-1:0] i_P1_wData,
    output logic              o_P1_ack,
    output logic [DATA_W-1:0] o_P1_rData,
    // DataMemory side
    output logic              o_DMem_we,
    output logic              o_DMem_sByte,
    output logic [ADDR_W-1:0] o_DMem_addr,
    output logic [DATA_W-1:0] o_DMem_wData,
    input  logic [DATA_W-1:0] i_DMem_rData,
    // Status
    output logic              o_busy,
    output logic              o_grant
);

    localparam logic FIXED_PRIO_BIT = (FIXED_PRIO != 0);

    state_t              r_state;
    logic                r_grant;
    logic                r_last;
    logic                r_busy;
    logic                r_dmem_we;
    logic                r_dmem_sbyte;
    logic [ADDR_W-1:0]   r_dmem_addr;
    logic [DATA_W-1:0]   r_dmem_wdata;
    logic                r_p0_ack;
    logic                r_p1_ack;
    logic [DATA_W-1:0]   r_p0_rdata;
    logic [DATA_W-1:0]   r_p1_rdata;

    logic                w_pick_grant;
    logic                w_pick_valid;

    rr_pick2 u_pick (
        .i_req0       (i_P0_req),
        .i_req1       (i_P1_req),
        .i_last       (r_last),
        .i_fixed_prio (FIXED_PRIO_BIT),
        .o_grant      (w_pick_grant),
        .o_valid      (w_pick_valid)
    );

    // Access sequencer: grant in IDLE, one memory cycle in ACCESS, ack in DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_grant      <= PORT_CPU;
            // Pointer says port 1 was served last, so port 0 wins the first tie.
            r_last       <= PORT_DBG;
            r_busy       <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_sbyte <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                IDLE: begin
                    r_dmem_we <= 1'b0;
                    if (w_pick_valid) begin
                        // Request fields are captured only here; later changes are ignored.
                        r_grant <= w_pick_grant;
                        r_busy  <= 1'b1;
                        r_state <= ACCESS;
                        if (w_pick_grant == PORT_DBG) begin
                            r_dmem_we    <= i_P1_we;
                            r_dmem_sbyte <= i_P1_sByte;
                            r_dmem_addr  <= i_P1_addr;
                            r_dmem_wdata <= i_P1_wData;
                        end else begin
                            r_dmem_we    <= i_P0_we;
                            r_dmem_sbyte <= i_P0_sByte;
                            r_dmem_addr  <= i_P0_addr;
                            r_dmem_wdata <= i_P0_wData;
                        end
                    end
                end

                ACCESS: begin
                    // Write commits at this edge; drop we so it lasts one cycle only.
                    r_dmem_we <= 1'b0;
                    r_state   <= DONE;
                    // Read data is captured on writes too; it is simply unused then.
                    if (r_grant == PORT_DBG) begin
                        r_p1_rdata <= i_DMem_rData;
                        r_p1_ack   <= 1'b1;
                    end else begin
                        r_p0_rdata <= i_DMem_rData;
                        r_p0_ack   <= 1'b1;
                    end
                end

                DONE: begin
                    r_p0_ack <= 1'b0;
                    r_p1_ack <= 1'b0;
                    r_last   <= r_grant;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end

                default: begin
                    r_dmem_we <= 1'b0;
                    r_p0_ack  <= 1'b0;
                    r_p1_ack  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign o_DMem_we    = r_dmem_we;
    assign o_DMem_sByte = r_dmem_sbyte;
    assign o_DMem_addr  = r_dmem_addr;
    assign o_DMem_wData = r_dmem_wdata;
    assign o_P0_ack     = r_p0_ack;
    assign o_P1_ack     = r_p1_ack;
    assign o_P0_rData   = r_p0_rdata;
    assign o_P1_rData   = r_p1_rdata;
    assign o_busy       = r_busy;
    assign o_grant      = r_grant;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance backed by a small
// word memory model with byte-merge writes, plus a fixed-priority instance.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Round-robin instance (a_*)
    logic        p0_req = 0, p0_we = 0, p0_sb = 0;
    logic [31:0] p0_addr = '0, p0_wd = '0;
    logic        p1_req = 0, p1_we = 0, p1_sb = 0;
    logic [31:0] p1_addr = '0, p1_wd = '0;
    logic        a_p0_ack, a_p1_ack, a_we, a_sb, a_busy, a_grant;
    logic [31:0] a_p0_rd, a_p1_rd, a_addr, a_wd, a_rd;

    // Fixed-priority instance (f_*)
    logic        f0_req = 0, f1_req = 0;
    logic        f_p0_ack, f_p1_ack, f_we, f_sb, f_busy, f_grant;
    logic [31:0] f_p0_rd, f_p1_rd, f_addr, f_wd;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .rstn(rstn),
        .i_P0_req(p0_req), .i_P0_we(p0_we), .i_P0_sByte(p0_sb),
        .i_P0_addr(p0_addr), .i_P0_wData(p0_wd),
        .o_P0_ack(a_p0_ack), .o_P0_rData(a_p0_rd),
        .i_P1_req(p1_req), .i_P1_we(p1_we), .i_P1_sByte(p1_sb),
        .i_P1_addr(p1_addr), .i_P1_wData(p1_wd),
        .o_P1_ack(a_p1_ack), .o_P1_rData(a_p1_rd),
        .o_DMem_we(a_we), .o_DMem_sByte(a_sb), .o_DMem_addr(a_addr),
        .o_DMem_wData(a_wd), .i_DMem_rData(a_rd),
        .o_busy(a_busy), .o_grant(a_grant)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) u_dut_fp (
        .clk(clk), .rstn(rstn),
        .i_P0_req(f0_req), .i_P0_we(1'b0), .i_P0_sByte(1'b0),
        .i_P0_addr(32'h0), .i_P0_wData(32'h0),
        .o_P0_ack(f_p0_ack), .o_P0_rData(f_p0_rd),
        .i_P1_req(f1_req), .i_P1_we(1'b0), .i_P1_sByte(1'b0),
        .i_P1_addr(32'h4), .i_P1_wData(32'h0),
        .o_P1_ack(f_p1_ack), .o_P1_rData(f_p1_rd),
        .o_DMem_we(f_we), .o_DMem_sByte(f_sb), .o_DMem_addr(f_addr),
        .o_DMem_wData(f_wd), .i_DMem_rData(f_addr),
        .o_busy(f_busy), .o_grant(f_grant)
    );

    // DataMemory model: 16 words, word i initialised to 0xiiiiiiii,
    // byte writes replace the low byte, byte reads are zero-extended.
    logic        mem_load = 1'b1;
    logic [31:0] mem [16];
    logic [3:0]  a_idx;
    assign a_idx = a_addr[5:2];
    assign a_rd  = a_sb ? {24'h0, mem[a_idx][7:0]} : mem[a_idx];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= {8{i[3:0]}};
        end else if (a_we) begin
            if (a_sb) mem[a_idx] <= {mem[a_idx][31:8], a_wd[7:0]};
            else      mem[a_idx] <= a_wd;
        end
    end

    // Monitor: ack counts, ack order with cycle stamps, we pulse lengths
    typedef struct { logic port; int cyc; } ack_ev_t;
    ack_ev_t ack_log[$];
    int cyc = 0;
    int p0_acks = 0, p1_acks = 0, fp0_acks = 0, fp1_acks = 0;
    int we_cnt = 0, we_run = 0, we_run_max = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_p0_ack) begin p0_acks++; ack_log.push_back('{1'b0, cyc}); end
        if (a_p1_ack) begin p1_acks++; ack_log.push_back('{1'b1, cyc}); end
        if (f_p0_ack) fp0_acks++;
        if (f_p1_ack) fp1_acks++;
        if (a_we) begin
            we_cnt++;
            we_run++;
            if (we_run > we_run_max) we_run_max = we_run;
        end else begin
            we_run = 0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // One complete transaction on the round-robin instance; lat counts
    // negedges from request to observed ack (20 means it never came).
    task automatic xfer(input logic port, input logic we, input logic sb,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
        @(negedge clk);
        if (port) begin p1_we = we; p1_sb = sb; p1_addr = addr; p1_wd = wd; p1_req = 1'b1; end
        else      begin p0_we = we; p0_sb = sb; p0_addr = addr; p0_wd = wd; p0_req = 1'b1; end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(port ? a_p1_ack : a_p0_ack) && lat < 20);
        rd = port ? a_p1_rd : a_p0_rd;
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", a_grant); end
        checks++; if ({a_p0_ack, a_p1_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {a_p0_ack, a_p1_ack}); end
        checks++; if ({a_we, a_sb} !== 2'b00) begin errors++; $display("FAIL reset_we_sb: got %b expected 00", {a_we, a_sb}); end
        checks++; if (a_addr !== 32'h0 || a_wd !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", a_addr, a_wd); end
        checks++; if (a_p0_rd !== 32'h0 || a_p1_rd !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", a_p0_rd, a_p1_rd); end
        mem_load = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_p0_read();
        @(negedge clk);
        p0_we = 0; p0_sb = 0; p0_addr = 32'h4; p0_req = 1;
        @(negedge clk);
        checks++; if (a_busy !== 1'b1 || a_addr !== 32'h4) begin errors++; $display("FAIL p0rd_access: busy/addr got %b/%h expected 1/00000004", a_busy, a_addr); end
        checks++; if (a_we !== 1'b0 || a_grant !== 1'b0) begin errors++; $display("FAIL p0rd_we_grant: got %b/%b expected 0/0", a_we, a_grant); end
        checks++; if (a_p0_ack !== 1'b0) begin errors++; $display("FAIL p0rd_early_ack: got %b expected 0", a_p0_ack); end
        @(negedge clk);
        checks++; if (a_p0_ack !== 1'b1 || a_p1_ack !== 1'b0) begin errors++; $display("FAIL p0rd_ack: p0/p1 got %b/%b expected 1/0", a_p0_ack, a_p1_ack); end
        checks++; if (a_p0_rd !== 32'h1111_1111) begin errors++; $display("FAIL p0rd_data: got %h expected 11111111", a_p0_rd); end
        checks++; if (a_p1_rd !== 32'h0) begin errors++; $display("FAIL p0rd_other_rdata: got %h expected 00000000", a_p1_rd); end
        p0_req = 0;
        @(negedge clk);
        checks++; if (a_p0_ack !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL p0rd_idle: ack/busy got %b/%b expected 0/0", a_p0_ack, a_busy); end
    endtask

    task automatic test_write_then_read();
        int lat;
        int we0;
        logic [31:0] rd;
        we0 = we_cnt;
        xfer(1'b0, 1'b1, 1'b0, 32'h8, 32'hDEAD_BEEF, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        xfer(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_data: got %h expected deadbeef", rd); end
        checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL wr_we_cycles: got %0d expected 1", we_cnt - we0); end
    endtask

    task automatic test_byte_write();
        int lat;
        logic [31:0] rd;
        @(negedge clk);
        p1_we = 1; p1_sb = 1; p1_addr = 32'hC; p1_wd = 32'h0000_00A5; p1_req = 1;
        @(negedge clk);
        checks++; if (a_we !== 1'b1 || a_sb !== 1'b1) begin errors++; $display("FAIL bw_we_sb: got %b/%b expected 1/1", a_we, a_sb); end
        checks++; if (a_wd !== 32'hA5 || a_grant !== 1'b1) begin errors++; $display("FAIL bw_wdata_grant: got %h/%b expected 000000a5/1", a_wd, a_grant); end
        @(negedge clk);
        checks++; if (a_p1_ack !== 1'b1 || a_we !== 1'b0) begin errors++; $display("FAIL bw_ack: ack/we got %b/%b expected 1/0", a_p1_ack, a_we); end
        p1_req = 0; p1_we = 0; p1_sb = 0;
        xfer(1'b0, 1'b0, 1'b0, 32'hC, 32'h0, lat, rd);
        checks++; if (rd !== 32'h3333_33A5) begin errors++; $display("FAIL bw_merged_word: got %h expected 333333a5", rd); end
    endtask

    task automatic test_round_robin();
        int base;
        apply_reset();
        @(negedge clk);
        base = ack_log.size();
        p0_we = 0; p0_sb = 0; p0_addr = 32'h10;
        p1_we = 0; p1_sb = 0; p1_addr = 32'h14;
        p0_req = 1; p1_req = 1;
        repeat (12) @(negedge clk);
        p0_req = 0; p1_req = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ack_log.size() - base !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d expected 4", ack_log.size() - base); end
        if (ack_log.size() - base >= 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ack_log[base+k].port !== k[0]) begin
                    errors++; $display("FAIL rr_order[%0d]: got port %b expected %b", k, ack_log[base+k].port, k[0]);
                end
                if (k > 0) begin
                    checks++;
                    if (ack_log[base+k].cyc - ack_log[base+k-1].cyc !== 3) begin
                        errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 3", k, ack_log[base+k].cyc - ack_log[base+k-1].cyc);
                    end
                end
            end
        end
        checks++; if (a_p0_rd !== 32'h4444_4444 || a_p1_rd !== 32'h5555_5555) begin errors++; $display("FAIL rr_rdata: got %h/%h expected 44444444/55555555", a_p0_rd, a_p1_rd); end
    endtask

    task automatic test_fixed_prio();
        int b0, b1;
        @(negedge clk);
        b0 = fp0_acks; b1 = fp1_acks;
        f0_req = 1; f1_req = 1;
        repeat (12) @(negedge clk);
        f0_req = 0;
        repeat (3) @(negedge clk);
        f1_req = 0;
        #1;
        checks++; if (fp0_acks - b0 !== 4) begin errors++; $display("FAIL fp_p0_acks: got %0d expected 4", fp0_acks - b0); end
        checks++; if (fp1_acks - b1 !== 1) begin errors++; $display("FAIL fp_p1_acks: got %0d expected 1", fp1_acks - b1); end
        checks++; if (f_grant !== 1'b1 || f_p1_rd !== 32'h4) begin errors++; $display("FAIL fp_final: grant/rdata got %b/%h expected 1/00000004", f_grant, f_p1_rd); end
    endtask

    task automatic test_reset_mid_write();
        int a0, a1, lat;
        logic [31:0] rd;
        @(negedge clk);
        a0 = p0_acks; a1 = p1_acks;
        p0_we = 1; p0_sb = 0; p0_addr = 32'h18; p0_wd = 32'h1234_5678; p0_req = 1;
        @(negedge clk);
        checks++; if (a_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %b expected 1", a_we); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (a_we !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL rst_we_cleared: we/busy got %b/%b expected 0/0", a_we, a_busy); end
        p0_req = 0; p0_we = 0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (p0_acks - a0 !== 0 || p1_acks - a1 !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d acks expected 0", (p0_acks - a0) + (p1_acks - a1)); end
        checks++; if (a_busy !== 1'b0 || a_addr !== 32'h0) begin errors++; $display("FAIL rst_idle: busy/addr got %b/%h expected 0/0", a_busy, a_addr); end
        xfer(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, lat, rd);
        checks++; if (lat !== 2 || rd !== 32'h1111_1111) begin errors++; $display("FAIL rst_next_req: lat/data got %0d/%h expected 2/11111111", lat, rd); end
    endtask

    task automatic test_addr_change();
        @(negedge clk);
        p1_we = 0; p1_sb = 0; p1_addr = 32'h20; p1_req = 1;
        @(negedge clk);
        p1_addr = 32'h24; p1_wd = 32'hFFFF_FFFF;
        #1;
        checks++; if (a_addr !== 32'h20 || a_grant !== 1'b1) begin errors++; $display("FAIL ac_latched_addr: addr/grant got %h/%b expected 00000020/1", a_addr, a_grant); end
        @(negedge clk);
        checks++; if (a_p1_ack !== 1'b1 || a_p1_rd !== 32'h8888_8888) begin errors++; $display("FAIL ac_rdata: ack/data got %b/%h expected 1/88888888", a_p1_ack, a_p1_rd); end
        p1_req = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_p0_read();
        test_write_then_read();
        test_byte_write();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid_write();
        test_addr_change();
        #1;
        checks++; if (we_run_max > 1) begin errors++; $display("FAIL we_single_cycle: longest we run %0d expected 1", we_run_max); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run can never hang
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single DataMemory port between two requesters: port 0 is the CPU load/store path, port 1 is the debug/DMA loader.
- Latches one request at a time and drives the DataMemory word/byte write and read signals for exactly one cycle.
- Registers the read data and returns a one-cycle acknowledge to the winning requester.
- Sits between the multi-cycle CPU datapath and DataMemory; DataMemory reads combinationally and writes on the rising clk edge.

Parameters:
ADDR_W, 32, address width of both requesters and the memory side
DATA_W, 32, data width
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins on conflict

Ports:
clk  in  1  system clock, all state changes on rising edge
rstn  in  1  asynchronous active-low reset
i_P0_req  in  1  CPU request; held high until o_P0_ack
i_P0_we  in  1  CPU write enable (0 = read)
i_P0_sByte  in  1  CPU byte access (low byte of wData / low byte of rData)
i_P0_addr  in  ADDR_W  CPU address
i_P0_wData  in  DATA_W  CPU write data
o_P0_ack  out  1  one-cycle completion pulse to CPU
o_P0_rData  out  DATA_W  CPU read data, valid while o_P0_ack is high
i_P1_req, i_P1_we, i_P1_sByte, i_P1_addr, i_P1_wData, o_P1_ack, o_P1_rData: same as the P0 group, for debug/DMA
o_DMem_we  out  1  to DataMemory write enable
o_DMem_sByte  out  1  to DataMemory byte select
o_DMem_addr  out  ADDR_W  to DataMemory address
o_DMem_wData  out  DATA_W  to DataMemory write data
i_DMem_rData  in  DATA_W  from DataMemory, combinational read
o_busy  out  1  high in ACCESS and DONE
o_grant  out  1  port currently or last served (0/1)

Behaviour:
- Reset values: state IDLE; all memory-side outputs 0; both acks 0; both rData 0; o_busy 0; o_grant 0; round-robin pointer favours port 0.
- Mid-operation reset clears o_DMem_we immediately. An aborted write is not guaranteed to land and no ack is issued.
- IDLE:
  - No req: stay in IDLE; o_DMem_we = 0; other memory outputs hold their last values.
  - One req high: grant that port.
  - Both reqs high, FIXED_PRIO = 1: grant port 0.
  - Both reqs high, FIXED_PRIO = 0: grant the port not served last. After reset, port 0 wins.
  - On grant: register the winner's we/sByte/addr/wData into the o_DMem_* outputs; set o_grant; go to ACCESS.
- ACCESS (1 cycle):
  - Memory sees the latched signals.
  - Write commits at the closing edge.
  - At the closing edge, i_DMem_rData is captured into the winner's rData register. The capture also happens on writes; the value is don't-care for writes.
  - The other port's rData is unchanged.
  - Go to DONE; o_DMem_we goes to 0 at that edge.
- DONE (1 cycle):
  - Winner's ack = 1.
  - Update the round-robin pointer to the winner.
  - Go to IDLE.
- Latency: req sampled in IDLE in cycle N -> ACCESS in N+1 -> ack in N+2. Next grant is no earlier than N+3. Throughput is one access per 3 cycles.
- Handshake:
  - A requester keeps req, we, sByte, addr and wData stable until it sees ack.
  - It drops req at the edge ending the ack cycle, so IDLE never re-grants a completed request.
  - Request fields are sampled only in IDLE; changes after the grant are ignored.
- Simultaneous events:
  - A new req from the loser during ACCESS/DONE waits and is served next (round-robin) with no loss.
  - A requester that drops req before ack is protocol misuse. The access still completes and ack still pulses.
- o_DMem_we is never high for more than one consecutive cycle per grant.
- sByte is passed through unchanged; byte merge and zero-extension stay inside DataMemory.

Decomposition:
- Shared package: state encoding constants (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2) and port-id constants PORT_CPU = 0 and PORT_DBG = 1.
- One natural sub-module, rr_pick2: a combinational two-way picker taking req0, req1, last, fixed_prio and producing a grant index and a valid flag.

Test Plan:
- P0 read of addr 0x4 alone -> o_DMem_addr = 0x4 in ACCESS; o_P0_ack at cycle+2; o_P0_rData = mem[0x4]; o_P1_ack stays 0.
- P0 write 0xDEADBEEF to 0x8, then P1 read of 0x8 -> o_DMem_we high for exactly 1 cycle; o_P1_rData = 0xDEADBEEF.
- P1 byte write (sByte = 1, wData = 0x000000A5) to 0xC, then P0 word read of 0xC -> o_DMem_sByte = 1 during the write ACCESS; the read returns DataMemory's byte-merged word.
- Both reqs held continuously, FIXED_PRIO = 0 -> grants alternate 0, 1, 0, 1; each ack is 3 cycles apart. With FIXED_PRIO = 1 -> port 0 is always granted while its req is high.
- Reset asserted during a write ACCESS -> o_DMem_we = 0 immediately; no ack; state IDLE after release; the next request completes normally.
- req changes addr after the grant -> the memory uses the originally latched addr; ack and rData correspond to the latched addr.
